if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high. Ports are clk and rst; all state updates on the rising edge of clk.
REQ-002 SHALL provide `clk  in  1  rising-edge clock`.
REQ-003 SHALL provide `rst  in  1  synchronous active-high reset`.
REQ-004 SHALL provide `enable  in  1  decode-advance from hazard unit; 1 = ID latches instruction this edge`.
REQ-005 SHALL provide `branch_taken  in  1  combinational redirect from ID`.
REQ-006 SHALL provide `branch_offst_imm  in  6  signed word offset from ID`.
REQ-007 SHALL provide `instruction  out  16  instruction presented to ID`.
REQ-008 SHALL provide `imem_req  out  1  instruction memory read request, one-cycle pulse`.
REQ-009 SHALL provide `imem_addr  out  8  word address, valid when imem_req=1`.
REQ-010 SHALL provide `imem_valid  in  1  read data valid, exactly one pulse per request, at least 1 cycle after the request`.
REQ-011 SHALL provide `imem_rdata  in  16  read data, valid when imem_valid=1`.
REQ-012 SHALL use parameter `FIFO_DEPTH, default 2, prefetch buffer entries`.

Function
REQ-013 SHALL keep fetch_pc[7:0], the address of the next request; it increments by 1 per issued request and wraps 8'hFF -> 8'h00.
REQ-014 SHALL keep a prefetch FIFO of FIFO_DEPTH entries {pc[7:0], instr[15:0]} with a count register.
REQ-015 SHALL allow at most one outstanding request.
REQ-016 SHALL run a fetch FSM with states IDLE (none outstanding), WAIT (one outstanding, keep data) and DROP (one outstanding, discard data).
REQ-017 SHALL drive imem_req=1 combinationally only when state=IDLE, count < FIFO_DEPTH, branch_taken=0 and rst=0.
REQ-018 SHALL drive imem_addr=fetch_pc.
REQ-019 SHALL apply these FSM transitions:
- IDLE -> WAIT on request.
- WAIT -> IDLE on imem_valid, pushing {request pc, imem_rdata}.
- WAIT -> DROP on branch_taken without imem_valid.
- WAIT -> IDLE on branch_taken with imem_valid, discarding the data.
- DROP -> IDLE on imem_valid, discarding the data.
- Branch while in DROP stays in DROP.
- imem_valid in IDLE is ignored.
REQ-020 SHALL make a pushed entry visible on instruction the cycle after imem_valid (no bypass); minimum request-to-ID latency is therefore 2 cycles.
REQ-021 SHALL drive instruction = FIFO head instr when count>0 and branch_taken=0, else 16'h0000 (NOP bubble).
REQ-022 SHALL pop the head on the edge where enable=1, count>0 and branch_taken=0, and load id_pc[7:0] with the head pc.
REQ-023 SHALL pop nothing and leave id_pc unchanged when enable=0 or count=0.
REQ-024 SHALL compute the branch target as id_pc + 1 + sign_extend(branch_offst_imm), modulo 256.
REQ-025 SHALL, on an edge with branch_taken=1:
- load fetch_pc with the target;
- flush the FIFO (count=0);
- ignore any pop;
- issue the first target request no earlier than the next cycle.
REQ-026 SHALL produce count' = count + push - pop when push and pop occur on the same edge; push never occurs with count=FIFO_DEPTH, by construction of REQ-017.
REQ-027 SHALL guarantee that enable=0 never loses or duplicates a FIFO entry and that fetching continues until the FIFO is full.

Reset
REQ-028 SHALL, with rst=1 on an edge, set fetch_pc=0, id_pc=0, count=0 and state=IDLE; while rst=1, imem_req=0 and instruction=16'h0000.
REQ-029 SHALL abandon any outstanding request when rst is asserted mid-operation; the instruction memory is reset by the same rst and SHALL NOT return that response.
REQ-030 SHALL issue the first request (addr 8'h00) in the first cycle with rst=0.

Verification
REQ-031 Single-cycle memory, enable=1: instruction shows mem[0], mem[1], mem[2]... with one NOP between entries (at most one outstanding request), and imem_addr wraps 8'hFF -> 8'h00.
REQ-032 enable=0 held 10 cycles: at most 2 requests are issued, then imem_req stays 0; on release, ID receives mem[0] then mem[1] back-to-back with no gap and no duplicates.
REQ-033 The instruction at pc=5 enters ID (id_pc=5), then branch_taken=1 with imm=6'b111110: that cycle instruction=0, the FIFO is flushed and the next imem_addr=8'h04.
REQ-034 Memory latency 3 with the request at pc=7 outstanding, branch_taken=1 (imm=+2, id_pc=6): the state goes to DROP, the late mem[7] is discarded, and the next request is at 8'h09.
REQ-035 Branch taken on the same cycle imem_valid returns: the data is discarded, state=IDLE, and the next cycle issues a request to the target.
REQ-036 rst asserted 1 cycle mid-WAIT with the FIFO holding 2 entries: the next cycle count=0, instruction=0, and imem_req=1 with imem_addr=8'h00.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: issues single-outstanding word reads to instruction memory,
// buffers returned words in a small prefetch FIFO and presents the head to decode.
module if_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        branch_taken,
  input  logic [5:0]  branch_offst_imm,
  output logic [15:0] instruction,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [1:0]  state_dbg
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  // Memory handshake: imem_req is a one-cycle pulse that launches a read of imem_addr;
  // the memory answers with exactly one imem_valid pulse one or more cycles later.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  fetch_state_e state_q, state_d;

  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic [7:0]    req_pc_q, req_pc_d;
  logic [7:0]    id_pc_q, id_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    fifo_pc_q [FIFO_DEPTH];
  logic [7:0]    fifo_pc_d [FIFO_DEPTH];
  logic [15:0]   fifo_instr_q [FIFO_DEPTH];
  logic [15:0]   fifo_instr_d [FIFO_DEPTH];

  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic [7:0]    head_pc;
  logic [15:0]   head_instr;
  logic [7:0]    branch_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_C) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign fifo_nonempty = (count_q != '0);
  assign head_pc       = fifo_pc_q[rd_ptr_q];
  assign head_instr    = fifo_instr_q[rd_ptr_q];
  assign branch_target = id_pc_q + 8'd1 + {{2{branch_offst_imm[5]}}, branch_offst_imm};
  assign pop           = enable && fifo_nonempty && !branch_taken && !rst;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; a branch while a read is in flight turns that read into a discard
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (imem_req) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          state_d = ST_IDLE;
        end else if (branch_taken) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_req  = (state_q == ST_IDLE) && (count_q < DEPTH_C) && !branch_taken && !rst;
    imem_addr = fetch_pc_q;
    push      = (state_q == ST_WAIT) && imem_valid && !branch_taken && !rst;
    state_dbg = state_q;
  end

  assign instruction = (fifo_nonempty && !branch_taken && !rst) ? head_instr : 16'h0000;

  // Datapath next-state: branch flushes the buffer and redirects fetch
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    id_pc_d      = id_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    if (imem_req) begin
      req_pc_d = fetch_pc_q;
    end

    if (branch_taken) begin
      fetch_pc_d = branch_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + 8'd1;
      end
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d               = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        id_pc_d  = head_pc;
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= 8'h00;
      req_pc_q   <= 8'h00;
      id_pc_q    <= 8'h00;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      id_pc_q    <= id_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage carries no reset; count and pointers qualify its contents
  always_ff @(posedge clk) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

endmodule
